pc_fetch_unit: RTL and testbench

- Program counter and instruction fetch sequencer for the 8-bit datapath.
- Holds the PC and fetches one 8-bit instruction per step from instruction memory using a ready handshake.
- Decodes the instruction into the type select and the register-file selects (write select, read port 1, read port 2).
- Holds the instruction until the execute stage signals done, then advances the PC or loads the branch address produced by the Type4 unit's Output0.

---
 rtl/pc_fetch_unit_if.sv | 24 ++
 rtl/pc_fetch_unit.sv | 112 +++++++++++
 tb/tb_pc_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch sequencer (master) and memory (slave).
// Handshake: the master holds Mem_Read and Mem_Address steady until it samples Mem_Ready high on a rising edge; Mem_Data is valid only in that cycle.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] Mem_Address;
    logic              Mem_Read;
    logic              Mem_Ready;
    logic [7:0]        Mem_Data;

    modport master (
        output Mem_Address,
        output Mem_Read,
        input  Mem_Ready,
        input  Mem_Data
    );

    modport slave (
        input  Mem_Address,
        input  Mem_Read,
        output Mem_Ready,
        output Mem_Data
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer for the 8-bit datapath.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_unit #(
    parameter int                ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 15
) (
    input  logic                Clock,
    input  logic                Reset_N,
    pc_fetch_unit_if.master     mem,
    output logic [7:0]          Instruction,
    output logic                Instr_Valid,
    output logic [1:0]          Type_Select,
    output logic [1:0]          Write_Register_Selection,
    output logic [1:0]          R_Signal1,
    output logic [1:0]          R_Signal2,
    input  logic                Exec_Done,
    input  logic                Branch_Enable,
    input  logic [ADDR_W-1:0]   Branch_Address,
    input  logic                Halt,
    output logic [ADDR_W-1:0]   PC,
    output logic                Fetch_Error,
    output logic [1:0]          Debug_State
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [7:0]        instr_next;
    logic              timeout;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] WD_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] wd_cnt;

    // Count fires on the edge that would make it reach TIMEOUT_CYCLES.
    assign timeout = (state == S_FETCH) && !mem.Mem_Ready && (wd_cnt == WD_LAST);

    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            wd_cnt      <= 4'd0;
            Fetch_Error <= 1'b0;
        end else begin
            if (state != S_FETCH || mem.Mem_Ready) begin
                wd_cnt <= 4'd0;
            end else begin
                wd_cnt <= wd_cnt + 4'd1;
            end
            if (timeout) begin
                Fetch_Error <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign Fetch_Error    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = PC;
        instr_next = Instruction;
        case (state)
            S_IDLE: begin
                state_next = Halt ? S_HALTED : S_FETCH;
            end
            S_FETCH: begin
                if (mem.Mem_Ready) begin
                    instr_next = mem.Mem_Data;
                    state_next = S_EXEC;
                end else if (timeout) begin
                    state_next = S_HALTED;
                end
            end
            S_EXEC: begin
                if (Exec_Done) begin
                    pc_next    = Branch_Enable ? Branch_Address : PC + ADDR_W'(1);
                    state_next = Halt ? S_HALTED : S_FETCH;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            state       <= S_IDLE;
            PC          <= RESET_PC;
            Instruction <= 8'h00;
        end else begin
            state       <= state_next;
            PC          <= pc_next;
            Instruction <= instr_next;
        end
    end

    assign mem.Mem_Address           = PC;
    assign mem.Mem_Read              = (state == S_FETCH);
    assign Instr_Valid               = (state == S_EXEC);
    assign Type_Select               = Instruction[7:6];
    assign Write_Register_Selection  = Instruction[5:4];
    assign R_Signal1                 = Instruction[3:2];
    assign R_Signal2                 = Instruction[1:0];
    assign Debug_State               = state;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: table-driven program run plus hand-written corner sequences.
module tb_pc_fetch_unit;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic       clk = 1'b0;
    logic       Reset_N;
    logic       Exec_Done;
    logic       Branch_Enable;
    logic [7:0] Branch_Address;
    logic       Halt;
    logic [7:0] Instruction;
    logic       Instr_Valid;
    logic [1:0] Type_Select;
    logic [1:0] Write_Register_Selection;
    logic [1:0] R_Signal1;
    logic [1:0] R_Signal2;
    logic [7:0] PC;
    logic       Fetch_Error;
    logic [1:0] dbg_state;
    logic       mem_ready;
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.ADDR_W(8)) mif ();
    assign mif.Mem_Data  = mem[mif.Mem_Address];
    assign mif.Mem_Ready = mem_ready;

    pc_fetch_unit #(
        .ADDR_W(8),
        .RESET_PC(8'h00),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .Clock(clk),
        .Reset_N(Reset_N),
        .mem(mif.master),
        .Instruction(Instruction),
        .Instr_Valid(Instr_Valid),
        .Type_Select(Type_Select),
        .Write_Register_Selection(Write_Register_Selection),
        .R_Signal1(R_Signal1),
        .R_Signal2(R_Signal2),
        .Exec_Done(Exec_Done),
        .Branch_Enable(Branch_Enable),
        .Branch_Address(Branch_Address),
        .Halt(Halt),
        .PC(PC),
        .Fetch_Error(Fetch_Error),
        .Debug_State(dbg_state)
    );

    typedef struct {
        logic [7:0] pc;
        logic [7:0] instr;
        logic       br_en;
        logic [7:0] br_addr;
        logic [1:0] ts;
        logic [1:0] wr;
        logic [1:0] r1;
        logic [1:0] r2;
        logic [7:0] next_pc;
    } vec_t;

    vec_t        vecs[8];
    logic [23:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_N = 1'b0;
        step();
        Reset_N = 1'b1;
        check("rst_state", dbg_state, S_IDLE);
        check("rst_pc", PC, 8'h00);
        check("rst_addr", mif.Mem_Address, 8'h00);
        check("rst_read", mif.Mem_Read, 1'b0);
        check("rst_instr", Instruction, 8'h00);
        check("rst_valid", Instr_Valid, 1'b0);
        check("rst_fields", {Type_Select, Write_Register_Selection, R_Signal1, R_Signal2}, 8'h00);
        check("rst_err", Fetch_Error, 1'b0);
    endtask

    initial begin
        logic [23:0] e;
        logic [7:0]  fetch_addr;
        int          read_cycles;

        vecs[0] = '{8'h00, 8'h1B, 1'b0, 8'h00, 2'd0, 2'd1, 2'd2, 2'd3, 8'h01};
        vecs[1] = '{8'h01, 8'hE4, 1'b0, 8'h00, 2'd3, 2'd2, 2'd1, 2'd0, 8'h02};
        vecs[2] = '{8'h02, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0, 8'h03};
        vecs[3] = '{8'h03, 8'h9C, 1'b1, 8'h05, 2'd2, 2'd1, 2'd3, 2'd0, 8'h05};
        vecs[4] = '{8'h05, 8'h6A, 1'b1, 8'h40, 2'd1, 2'd2, 2'd2, 2'd2, 8'h40};
        vecs[5] = '{8'h40, 8'hFF, 1'b1, 8'hFF, 2'd3, 2'd3, 2'd3, 2'd3, 8'hFF};
        vecs[6] = '{8'hFF, 8'h37, 1'b0, 8'h00, 2'd0, 2'd3, 2'd1, 2'd3, 8'h00};
        vecs[7] = '{8'h00, 8'h1B, 1'b0, 8'h00, 2'd0, 2'd1, 2'd2, 2'd3, 8'h01};

        for (int a = 0; a < 256; a++) mem[a] = 8'(a ^ 8'h5A);
        for (int i = 0; i < 8; i++) mem[vecs[i].pc] = vecs[i].instr;

        Reset_N        = 1'b0;
        Exec_Done      = 1'b0;
        Branch_Enable  = 1'b0;
        Branch_Address = 8'h00;
        Halt           = 1'b0;
        mem_ready      = 1'b1;
        step();

        // Table-driven program: sequential, branch, wrap.
        do_reset();
        step();
        for (int i = 0; i < 8; i++) begin
            check("fetch_state", dbg_state, S_FETCH);
            check("fetch_read", mif.Mem_Read, 1'b1);
            check("fetch_addr", mif.Mem_Address, vecs[i].pc);
            exp_q.push_back({vecs[i].instr, vecs[i].ts, vecs[i].wr, vecs[i].r1, vecs[i].r2, vecs[i].pc});
            fetch_addr = mif.Mem_Address;
            step();
            check("exec_valid", Instr_Valid, 1'b1);
            check("exec_read", mif.Mem_Read, 1'b0);
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
                e = '0;
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", Instruction, e[23:16]);
                check("sb_type", Type_Select, e[15:14]);
                check("sb_wr", Write_Register_Selection, e[13:12]);
                check("sb_r1", R_Signal1, e[11:10]);
                check("sb_r2", R_Signal2, e[9:8]);
                check("sb_addr", fetch_addr, e[7:0]);
            end
            Branch_Enable  = 1'b1;
            Branch_Address = 8'hAA;
            step();
            check("br_no_done_pc", PC, vecs[i].pc);
            check("hold_valid", Instr_Valid, 1'b1);
            check("hold_fields", {Type_Select, Write_Register_Selection, R_Signal1, R_Signal2}, e[15:8]);
            Exec_Done      = 1'b1;
            Branch_Enable  = vecs[i].br_en;
            Branch_Address = vecs[i].br_addr;
            step();
            Exec_Done     = 1'b0;
            Branch_Enable = 1'b0;
            check("next_pc", PC, vecs[i].next_pc);
            check("next_valid", Instr_Valid, 1'b0);
        end
        check("sb_empty", exp_q.size(), 0);

        // Wait states: three not-ready cycles then ready.
        mem_ready = 1'b0;
        do_reset();
        step();
        read_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            if (mif.Mem_Read) read_cycles++;
            check("wait_valid", Instr_Valid, 1'b0);
            check("wait_instr", Instruction, 8'h00);
            mem_ready = (k == 3);
            step();
        end
        check("wait_read_cycles", read_cycles, 4);
        check("wait_read_done", mif.Mem_Read, 1'b0);
        check("wait_captured", Instruction, 8'h1B);
        check("wait_exec", Instr_Valid, 1'b1);

        // Reset during FETCH abandons the read.
        mem_ready = 1'b0;
        Exec_Done = 1'b1;
        step();
        Exec_Done = 1'b0;
        check("rf_read_before", mif.Mem_Read, 1'b1);
        check("rf_pc_before", PC, 8'h01);
        do_reset();
        step();
        check("rf_refetch_state", dbg_state, S_FETCH);
        check("rf_refetch_addr", mif.Mem_Address, 8'h00);
        check("rf_refetch_read", mif.Mem_Read, 1'b1);

        // Halt raised mid-FETCH: fetch completes, executes, then halts.
        Halt = 1'b1;
        step();
        check("halt_fetch_held", mif.Mem_Read, 1'b1);
        mem_ready = 1'b1;
        step();
        check("halt_exec_valid", Instr_Valid, 1'b1);
        check("halt_exec_instr", Instruction, 8'h1B);
        Exec_Done = 1'b1;
        step();
        Exec_Done = 1'b0;
        Halt      = 1'b0;
        check("halted_state", dbg_state, S_HALTED);
        check("halted_pc", PC, 8'h01);
        for (int k = 0; k < 10; k++) begin
            Exec_Done = $urandom_range(0, 1);
            mem_ready = $urandom_range(0, 1);
            step();
            check("halted_read", mif.Mem_Read, 1'b0);
            check("halted_valid", Instr_Valid, 1'b0);
            check("halted_pc_hold", PC, 8'h01);
            check("halted_instr_hold", Instruction, 8'h1B);
        end
        Exec_Done = 1'b0;

        // Halt seen in IDLE goes straight to HALTED.
        Halt = 1'b1;
        do_reset();
        step();
        Halt = 1'b0;
        check("idle_halt_state", dbg_state, S_HALTED);
        check("idle_halt_read", mif.Mem_Read, 1'b0);

        // Watchdog: ready on the 14th cycle gives no error.
        mem_ready = 1'b0;
        do_reset();
        step();
        for (int c = 1; c <= 14; c++) begin
            check("wd14_err", Fetch_Error, 1'b0);
            mem_ready = (c == 14);
            step();
        end
        check("wd14_valid", Instr_Valid, 1'b1);
        check("wd14_err_after", Fetch_Error, 1'b0);

        // Watchdog: ready held low.
        mem_ready = 1'b0;
        Exec_Done = 1'b1;
        step();
        Exec_Done = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            check("wd15_err_before", Fetch_Error, 1'b0);
            check("wd15_read_before", mif.Mem_Read, 1'b1);
            step();
        end
`ifdef FETCH_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            check("wd_err_set", Fetch_Error, 1'b1);
            check("wd_read_drop", mif.Mem_Read, 1'b0);
            check("wd_state", dbg_state, S_HALTED);
            mem_ready = (k == 2);
            step();
        end
`else
        for (int k = 0; k < 20; k++) begin
            check("nowd_err", Fetch_Error, 1'b0);
            check("nowd_read", mif.Mem_Read, 1'b1);
            step();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
